// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs and datapath width.
// Imported by the decode/write-back stage and its register file.
package y86_pkg;

  localparam int WIDTH = 64;
  localparam int NREGS = 15;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/reg_file.sv
// Y86-64 program register file: 15 registers, two operand read ports, one debug read port,
// two write ports where port M overrides port E on the same register.
module reg_file
  import y86_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rd_a,
  input  logic [3:0]       rd_b,
  input  logic [3:0]       rd_dbg,
  output logic [WIDTH-1:0] val_a,
  output logic [WIDTH-1:0] val_b,
  output logic [WIDTH-1:0] val_dbg,
  input  logic             we_e,
  input  logic [3:0]       dst_e,
  input  logic [WIDTH-1:0] val_e,
  input  logic             we_m,
  input  logic [3:0]       dst_m,
  input  logic [WIDTH-1:0] val_m
);

  logic [WIDTH-1:0] regs [NREGS];

  // Checking port M first gives popq %rsp a single, well-defined commit of valm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m && dst_m == 4'(i))
          regs[i] <= val_m;
        else if (we_e && dst_e == 4'(i))
          regs[i] <= val_e;
      end
    end
  end

  // IDs with no backing register (RNONE) fall through to the zero default.
  always_comb begin
    val_a   = '0;
    val_b   = '0;
    val_dbg = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_a == 4'(i))   val_a   = regs[i];
      if (rd_b == 4'(i))   val_b   = regs[i];
      if (rd_dbg == 4'(i)) val_dbg = regs[i];
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode and write-back stage: register selection from icode/rA/rB,
// combinational operand reads and edge-triggered commit of vale/valm.
module decode_writeback
  import y86_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic             cnd,
  input  logic [WIDTH-1:0] vale,
  input  logic [WIDTH-1:0] valm,
  input  logic             wb_en,
  output logic [WIDTH-1:0] vala,
  output logic [WIDTH-1:0] valb,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_val
);

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       we_e;
  logic       we_m;

  // Register selectors; anything not listed (halt, nop, jXX, unknown codes) uses RNONE.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IRRMOVQ: begin
        src_a = ra;
        dst_e = cnd ? rb : RNONE;
      end
      IIRMOVQ: dst_e = rb;
      IRMMOVQ: begin
        src_a = ra;
        src_b = rb;
      end
      IMRMOVQ: begin
        src_b = rb;
        dst_m = ra;
      end
      IOPQ: begin
        src_a = ra;
        src_b = rb;
        dst_e = rb;
      end
      ICALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      IRET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPUSHQ: begin
        src_a = ra;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPOPQ: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = ra;
      end
      default: ;
    endcase
  end

  assign we_e = wb_en && (dst_e != RNONE);
  assign we_m = wb_en && (dst_m != RNONE);

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .rd_a    (src_a),
    .rd_b    (src_b),
    .rd_dbg  (dbg_sel),
    .val_a   (vala),
    .val_b   (valb),
    .val_dbg (dbg_val),
    .we_e    (we_e),
    .dst_e   (dst_e),
    .val_e   (vale),
    .we_m    (we_m),
    .dst_m   (dst_m),
    .val_m   (valm)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus random instruction
// streams compared against an architectural register-array model.
module tb_decode_writeback;

  logic        clk;
  logic        rst;
  logic [3:0]  icode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        cnd;
  logic [63:0] vale;
  logic [63:0] valm;
  logic        wb_en;
  logic [63:0] vala;
  logic [63:0] valb;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [15];

  decode_writeback dut (
    .clk     (clk),
    .rst     (rst),
    .icode   (icode),
    .ra      (ra),
    .rb      (rb),
    .cnd     (cnd),
    .vale    (vale),
    .valm    (valm),
    .wb_en   (wb_en),
    .vala    (vala),
    .valb    (valb),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] modelRead(input logic [3:0] id);
    return (id < 4'd15) ? model[id] : 64'd0;
  endfunction

  // Architectural register roles per instruction, written as membership rules.
  function automatic logic [3:0] refSrcA(input logic [3:0] ic, input logic [3:0] a);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] refSrcB(input logic [3:0] ic, input logic [3:0] b);
    if (ic inside {4'h4, 4'h5, 4'h6}) return b;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] refDstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
    if (ic == 4'h2) return c ? b : 4'hF;
    if (ic inside {4'h3, 4'h6}) return b;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] refDstM(input logic [3:0] ic, input logic [3:0] a);
    return (ic inside {4'h5, 4'hB}) ? a : 4'hF;
  endfunction

  // Walks every debug select, including 15, which has no register behind it.
  task automatic scanRegs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      checkOutput($sformatf("%s_dbg%0d", tag, i), dbg_val, modelRead(4'(i)));
    end
  endtask

  // One instruction: drive after negedge, check operands, commit at posedge, check state.
  task automatic applyStimulus(input string tag, input logic [3:0] ic, input logic [3:0] a,
                               input logic [3:0] b, input logic c, input logic [63:0] ve,
                               input logic [63:0] vm, input logic en);
    logic [3:0] de;
    logic [3:0] dm;
    @(negedge clk);
    icode = ic; ra = a; rb = b; cnd = c; vale = ve; valm = vm; wb_en = en;
    #1;
    checkOutput({tag, "_vala"}, vala, modelRead(refSrcA(ic, a)));
    checkOutput({tag, "_valb"}, valb, modelRead(refSrcB(ic, b)));
    @(posedge clk);
    de = refDstE(ic, b, c);
    dm = refDstM(ic, a);
    if (en) begin
      if (de != 4'hF) model[de] = ve;
      if (dm != 4'hF) model[dm] = vm;
    end
    #1;
    scanRegs(tag);
  endtask

  // Reset raised mid-cycle with a write pending; the following edge must not commit it.
  task automatic midReset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    icode = 4'h3; rb = 4'h5; vale = 64'hFFFF_0000_FFFF_0000; wb_en = 1'b1;
    for (int i = 0; i < 15; i++) model[i] = 64'd0;
    scanRegs({tag, "_imm"});
    @(posedge clk);
    #1;
    scanRegs({tag, "_edge"});
    @(negedge clk);
    rst = 1'b0;
    wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; icode = 4'h1; ra = 4'hF; rb = 4'hF; cnd = 1'b0;
    vale = '0; valm = '0; wb_en = 1'b0; dbg_sel = '0;
    for (int i = 0; i < 15; i++) model[i] = 64'd0;
    #5;
    scanRegs("reset");
    @(negedge clk);
    rst = 1'b0;

    // irmovq into r2, then OPq reads it on both ports.
    applyStimulus("t2w", 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1);
    checkOutput("t2_reg2", modelRead(4'h2), 64'h1234);
    applyStimulus("t2r", 4'h6, 4'h2, 4'h2, 1'b0, 64'h2468, 64'h0, 1'b0);

    // cmov blocked then taken.
    applyStimulus("t3n", 4'h2, 4'h2, 4'h3, 1'b0, 64'h55, 64'h0, 1'b1);
    applyStimulus("t3y", 4'h2, 4'h2, 4'h3, 1'b1, 64'h55, 64'h0, 1'b1);

    // popq %rsp: memory value wins over the stack-pointer update.
    applyStimulus("t4s", 4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 1'b1);
    applyStimulus("t4p", 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABC, 1'b1);
    checkOutput("t4_rsp", modelRead(4'h4), 64'hABC);

    // mrmovq stalled, then committed.
    applyStimulus("t5n", 4'h5, 4'h7, 4'h1, 1'b0, 64'h0, 64'hDEAD, 1'b0);
    applyStimulus("t5y", 4'h5, 4'h7, 4'h1, 1'b0, 64'h0, 64'hDEAD, 1'b1);

    // pushq reads the pushed register and %rsp, then updates %rsp.
    applyStimulus("t6a", 4'h3, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0, 1'b1);
    applyStimulus("t6b", 4'h3, 4'hF, 4'h4, 1'b0, 64'h200, 64'h0, 1'b1);
    applyStimulus("t6p", 4'hA, 4'h1, 4'hF, 1'b0, 64'h1F8, 64'h0, 1'b1);
    checkOutput("t6_rsp", modelRead(4'h4), 64'h1F8);

    // Full-width value into the highest register.
    applyStimulus("wide", 4'h3, 4'hF, 4'hE, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0, 1'b1);

    midReset("rst1");

    for (int n = 0; n < 300; n++) begin
      applyStimulus($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)), 4'($urandom),
                    4'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    ($urandom_range(0, 7) != 0));
      if (n == 150) midReset("rst2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
